// File: rtl/uart_pkg.sv
// Shared UART constants and helpers.
// Contents:
//   DVSR_W_DEF      default width of the baud divisor and its counter
//   OVERSAMPLE_DEF  default number of sample ticks per bit period
//   calc_divsr()    divisor for a given system clock and baud rate
package uart_pkg;

   localparam int DVSR_W_DEF     = 11;
   localparam int OVERSAMPLE_DEF = 16;

   // divsr = clk_hz / (oversample * baud) - 1, e.g. 50 MHz / 4800 baud -> 650.
   // Integer division truncates, so the resulting baud rate is slightly high
   // rather than slightly low.
   function automatic int unsigned calc_divsr(
      input int unsigned clk_hz,
      input int unsigned baud,
      input int unsigned oversample = OVERSAMPLE_DEF
   );
      return clk_hz / (oversample * baud) - 1;
   endfunction

endpackage

// File: rtl/baud_rate_gen_if.sv
// Divisor / tick bundle between the divisor register and the baud generator.
// Signals:
//   divsr     divisor, tick period = divsr+1 clk cycles
//   tick      one-cycle sample-tick pulse
//   bit_tick  one-cycle bit-period pulse (only with BAUD_GEN_BIT_TICK_EN)
// Modports:
//   master  drives divsr, receives the ticks (register block / UART engines)
//   slave   the baud generator itself
interface baud_rate_gen_if
   import uart_pkg::*;
#(
   parameter int DVSR_W = DVSR_W_DEF
) ();

   logic [DVSR_W-1:0] divsr;
   logic              tick;
`ifdef BAUD_GEN_BIT_TICK_EN
   logic              bit_tick;
`endif

   modport master (
      output divsr,
      input  tick
`ifdef BAUD_GEN_BIT_TICK_EN
      , input bit_tick
`endif
   );

   modport slave (
      input  divsr,
      output tick
`ifdef BAUD_GEN_BIT_TICK_EN
      , output bit_tick
`endif
   );

endinterface

// File: rtl/baud_rate_gen.sv
// Programmable baud-rate tick generator.
// A free-running counter divides clk by (divsr+1) and emits a registered
// one-cycle tick used as the 16x oversampling tick by the UART TX/RX engines.
// Optional build macro BAUD_GEN_BIT_TICK_EN adds bit_tick, a one-cycle pulse
// coincident with every OVERSAMPLE-th tick.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    baud_rate_gen_if.slave: divsr in, tick (and bit_tick) out
module baud_rate_gen
   import uart_pkg::*;
#(
   parameter int DVSR_W     = DVSR_W_DEF,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   baud_rate_gen_if.slave bus
);

   if (OVERSAMPLE < 1) begin : g_bad_oversample
      $error("baud_rate_gen: OVERSAMPLE must be at least 1");
   end

   logic [DVSR_W-1:0] cnt;
   logic              wrap;

   // ">=" rather than "==" so a divisor shrunk below the current count
   // wraps on the next edge instead of rolling around the full counter range.
   assign wrap = (cnt >= bus.divsr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         bus.tick <= 1'b0;
      end else if (wrap) begin
         cnt      <= '0;
         bus.tick <= 1'b1;
      end else begin
         cnt      <= cnt + 1'b1;
         bus.tick <= 1'b0;
      end
   end

`ifdef BAUD_GEN_BIT_TICK_EN
   localparam int              OS_W    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

   logic [OS_W-1:0] os_cnt;

   // Advances only on wraps, so bit_tick lands on the same edge as tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         os_cnt       <= '0;
         bus.bit_tick <= 1'b0;
      end else if (wrap) begin
         if (os_cnt == OS_LAST) begin
            os_cnt       <= '0;
            bus.bit_tick <= 1'b1;
         end else begin
            os_cnt       <= os_cnt + 1'b1;
            bus.bit_tick <= 1'b0;
         end
      end else begin
         bus.bit_tick <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_baud_rate_gen.sv
// Bench for baud_rate_gen: directed scenarios plus randomized divisor
// segments, checked cycle by cycle against an edge-count reference model.
module tb_baud_rate_gen;
   import uart_pkg::*;

   localparam int DW = DVSR_W_DEF;
   localparam int OS = OVERSAMPLE_DEF;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   baud_rate_gen_if #(.DVSR_W(DW)) bus ();

   baud_rate_gen #(
      .DVSR_W     (DW),
      .OVERSAMPLE (OS)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: the generator wraps on any edge where the number of
   // edges elapsed since the previous wrap (or reset) has reached divsr.
   longint      edge_idx;
   longint      last_wrap_idx;
   longint      n_wraps;
   int unsigned dv;
   bit          exp_tick;
   bit          exp_bit;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      edge_idx      = 0;
      last_wrap_idx = 0;
      n_wraps       = 0;
      exp_tick      = 1'b0;
      exp_bit       = 1'b0;
   endtask

   task automatic set_divsr(input int unsigned v);
      dv        = v;
      bus.divsr = DW'(v);
   endtask

   task automatic step();
      @(posedge clk);
      edge_idx++;
      if (edge_idx - last_wrap_idx - 1 >= longint'(dv)) begin
         exp_tick      = 1'b1;
         last_wrap_idx = edge_idx;
         n_wraps++;
         exp_bit       = ((n_wraps % OS) == 0);
      end else begin
         exp_tick = 1'b0;
         exp_bit  = 1'b0;
      end
      #1;
      check("tick", 32'(bus.tick), 32'(exp_tick));
`ifdef BAUD_GEN_BIT_TICK_EN
      check("bit_tick", 32'(bus.bit_tick), 32'(exp_bit));
`endif
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Called just after a step (posedge+1): asserts reset mid-cycle and checks
   // that state clears before any further clock edge.
   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      check("rst_tick", 32'(bus.tick), 32'd0);
      check("rst_cnt", 32'(dut.cnt), 32'd0);
`ifdef BAUD_GEN_BIT_TICK_EN
      check("rst_bit_tick", 32'(bus.bit_tick), 32'd0);
      check("rst_os_cnt", 32'(dut.os_cnt), 32'd0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      #5ms;
      $display("FAIL timeout: simulation did not complete, %0d checks, %0d errors", n_chk, n_err);
      $fatal(1, "timeout");
   end

   initial begin
      time t_prev;
      bit  first;
      int unsigned v;

      model_reset();
      set_divsr(calc_divsr(50_000_000, 4800));
      #12;
      check("tick_in_reset", 32'(bus.tick), 32'd0);
      #8 rst_n = 1'b1;

      // Period: first tick at edge divsr+1, then every (divsr+1)*10 ns.
      t_prev = 0;
      first  = 1'b1;
      for (int i = 0; i < 3 * 651 + 5; i++) begin
         step();
         if (bus.tick) begin
            if (first) check("first_tick_edge", 32'(edge_idx), 32'(dv + 1));
            else       check("tick_period_ns", 32'($time - t_prev), 32'((dv + 1) * 10));
            first  = 1'b0;
            t_prev = $time;
         end
      end

      // Divide-by-1 and divide-by-2.
      set_divsr(0);
      run(10);
      set_divsr(1);
      run(10);

      // Shrink mid-count: cnt=300, divisor 650 -> 100.
      async_reset();
      set_divsr(650);
      run(300);
      set_divsr(100);
      run(250);

      // Grow mid-count: cnt=5, divisor 10 -> 20.
      async_reset();
      set_divsr(10);
      run(5);
      set_divsr(20);
      run(60);

      // Async reset at cnt=400, then full first period after release.
      async_reset();
      set_divsr(650);
      run(400);
      async_reset();
      run(700);

      // Async reset while tick is held high.
      set_divsr(0);
      run(3);
      async_reset();
      run(4);

      // Largest divisor: one full 2048-cycle period.
      set_divsr((1 << DW) - 1);
      async_reset();
      run(2050);

      // Randomized divisor segments, mostly small, occasionally full range.
      for (int seg = 0; seg < 30; seg++) begin
         if ($urandom_range(0, 9) == 0) v = $urandom_range(0, (1 << DW) - 1);
         else                           v = $urandom_range(0, 40);
         set_divsr(v);
         run($urandom_range(1, 150));
         if ($urandom_range(0, 5) == 0) async_reset();
      end

`ifdef BAUD_GEN_BIT_TICK_EN
      // bit_tick every OS*(divsr+1) cycles, cleared by reset.
      async_reset();
      set_divsr(3);
      run(200);
      async_reset();
      run(140);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/baud_rate_gen.md
Name: baud_rate_gen

Overview:
- Programmable baud-rate tick generator for the UART.
- Free-running counter divides the system clock by (divsr+1).
- Emits a one-clock `tick` pulse used as the 16x oversampling sample tick by the transmitter and receiver.
- Sits between the APB-configured divisor register and the UART TX/RX engines.

Parameters:
- DVSR_W, 11, width of divisor input and internal counter.
- OVERSAMPLE, 16, sample ticks per bit period; used only by the optional bit-tick output.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- divsr  input  DVSR_W  divisor; tick period = divsr+1 clk cycles.
- tick  output  1  one-cycle sample-tick pulse, registered.
- bit_tick  output  1  one-cycle bit-period pulse; present only with BAUD_GEN_BIT_TICK_EN.

Behaviour:
- One clock domain; asynchronous active-low reset.
- Reset (rst_n=0, asynchronous): cnt=0, tick=0, bit_tick=0, oversample counter=0.
- Each rising clk edge with rst_n=1:
  - If cnt >= divsr: cnt<=0, tick<=1 (wrap).
  - Else: cnt<=cnt+1, tick<=0.
- tick is a registered output, high exactly one clk cycle per wrap. No combinational path from divsr to tick.
- First tick after reset release: tick rises at the (divsr+1)-th rising edge; then one tick every divsr+1 cycles.
  - Example: divsr=650 at 100 MHz gives a 6.51 us period.
- divsr=0: wrap every edge, so tick stays continuously high after the first edge (divide-by-1).
- divsr=all ones (2047): period 2048 cycles. Counter never overflows its width.
- divsr changed mid-count:
  - New value used on the next edge.
  - If cnt >= new divsr, wrap immediately on that edge; no long roll-around through 2^DVSR_W.
- divsr is sampled live and is assumed quasi-static / same clock domain. No internal synchroniser.
- Reset asserted mid-count: all state clears immediately. Counting restarts from 0 on release.
- Unsigned arithmetic only, DVSR_W-bit compare.

Optional Feature:
- Macro: BAUD_GEN_BIT_TICK_EN.
- Defined:
  - Adds output bit_tick and a ceil(log2(OVERSAMPLE))-bit counter `os_cnt`, advanced on each tick wrap.
  - When a wrap occurs with os_cnt==OVERSAMPLE-1: os_cnt<=0 and bit_tick<=1, coincident with that tick. Otherwise bit_tick<=0.
  - bit_tick period = OVERSAMPLE*(divsr+1) cycles.
  - os_cnt and bit_tick are cleared by rst_n.
- Undefined: no bit_tick port, no os_cnt logic. tick behaviour identical in both builds.

Decomposition:
- Shared package uart_pkg:
  - DVSR_W default constant.
  - OVERSAMPLE default constant (16).
  - Divisor helper constant function: divsr = clk_hz/(OVERSAMPLE*baud) - 1, e.g. 50 MHz / 4800 baud gives 650.
- Single flat module, no sub-module.
- The optional oversample counter stays inline; it is too small to warrant its own block.

Test Plan:
- Reset and period: clk 10 ns, rst_n low 20 ns then high, divsr=650 -> tick=0 during reset; first tick at edge 651; subsequent ticks exactly 6510 ns apart, each 10 ns wide.
- divsr=0 -> tick high every cycle after the first edge. divsr=1 -> tick alternates 0/1 with period 20 ns.
- Divisor shrink mid-count: divsr=650, wait until cnt=300, set divsr=100 -> tick on the next edge, then every 101 cycles.
- Divisor grow mid-count: divsr=10 with cnt=5, set divsr=20 -> next tick 16 cycles later, then every 21 cycles.
- Async reset mid-count: assert rst_n between edges at cnt≈400 -> tick=0 and cnt=0 immediately without a clock; after release, first tick at edge divsr+1.
- With BAUD_GEN_BIT_TICK_EN, divsr=3 -> tick every 4 cycles; bit_tick every 64 cycles, coincident with every 16th tick, cleared by reset.
